// File: rtl/svm_pkg.sv
// Shared constants and types for the SVM dot-product chunk accumulator.
package svm_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic FP_OP_ADD = 1'b0;
  localparam logic FP_OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_PART = 2'd1,
    ADD       = 2'd2,
    DONE      = 2'd3
  } accum_state_t;

endpackage

// File: rtl/fp_arith.sv
// Two-stage IEEE-754 single-precision add/sub unit.
// Denormals flush to zero and the result is truncated, not rounded.
module fp_arith
  import svm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  op_sel,
  input  logic [DATA_WIDTH-1:0] data_1,
  input  logic [DATA_WIDTH-1:0] data_2,
  output logic [DATA_WIDTH-1:0] data_accum_o,
  output logic                  data_o_vld
);

  logic [DATA_WIDTH-1:0] opA_q, opB_q, sum_q, sum_d;
  logic                  opSub_q, stage1Vld_q, outVld_q;

  logic              signA, signB, bigS, smallS;
  logic [7:0]        expA, expB, bigE, smallE, expDiff;
  logic [23:0]       manA, manB, bigM, smallM;
  logic [25:0]       bigExt, smallExt;
  logic [26:0]       mag;
  logic signed [9:0] resE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opA_q       <= '0;
      opB_q       <= '0;
      opSub_q     <= 1'b0;
      stage1Vld_q <= 1'b0;
      outVld_q    <= 1'b0;
      sum_q       <= '0;
    end else begin
      stage1Vld_q <= en;
      outVld_q    <= stage1Vld_q;
      if (en) begin
        opA_q   <= data_1;
        opB_q   <= data_2;
        opSub_q <= op_sel;
      end
      if (stage1Vld_q) begin
        sum_q <= sum_d;
      end
    end
  end

  // Align the smaller magnitude to the larger, add or subtract, then renormalize.
  always_comb begin
    signA = opA_q[31];
    signB = opB_q[31] ^ (opSub_q == FP_OP_SUB);
    expA  = opA_q[30:23];
    expB  = opB_q[30:23];
    manA  = (expA == 8'd0) ? 24'd0 : {1'b1, opA_q[22:0]};
    manB  = (expB == 8'd0) ? 24'd0 : {1'b1, opB_q[22:0]};

    if ({expB, manB} > {expA, manA}) begin
      bigS = signB; bigE = expB; bigM = manB;
      smallS = signA; smallE = expA; smallM = manA;
    end else begin
      bigS = signA; bigE = expA; bigM = manA;
      smallS = signB; smallE = expB; smallM = manB;
    end

    expDiff  = bigE - smallE;
    bigExt   = {bigM, 2'b00};
    smallExt = (expDiff > 8'd25) ? 26'd0 : ({smallM, 2'b00} >> expDiff);

    if (bigS == smallS) begin
      mag = {1'b0, bigExt} + {1'b0, smallExt};
    end else begin
      mag = {1'b0, bigExt} - {1'b0, smallExt};
    end

    resE = $signed({2'b00, bigE});
    if (mag[26]) begin
      mag  = mag >> 1;
      resE = resE + 10'sd1;
    end
    for (int i = 0; i < 25; i++) begin
      if (!mag[25] && (mag != 27'd0)) begin
        mag  = mag << 1;
        resE = resE - 10'sd1;
      end
    end

    if ((mag == 27'd0) || (bigE == 8'd0) || (resE <= 10'sd0)) begin
      sum_d = '0;
    end else if (resE >= 10'sd255) begin
      sum_d = {bigS, 8'hFF, 23'd0};
    end else begin
      sum_d = {bigS, resE[7:0], mag[24:2]};
    end
  end

  assign data_accum_o = sum_q;
  assign data_o_vld   = outVld_q;

endmodule

// File: rtl/svm_chunk_accum.sv
// Combines num_chunks partial sums from the vector adder tree into one
// floating-point dot-product result using a single shared adder.
module svm_chunk_accum #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_chunks,
  input  logic [DATA_WIDTH-1:0] part_data,
  input  logic                  part_vld,
  output logic                  part_rdy,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_vld,
  output logic                  busy,
  output logic                  err
);
  import svm_pkg::*;

  accum_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] accum_q, accum_d;
  logic [DATA_WIDTH-1:0] partOp_q, partOp_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, num_q, num_d, cntInc;
  logic                  addEn_q, addEn_d;
  logic                  err_q, err_d;
  logic                  rstN, addVld;
  logic [DATA_WIDTH-1:0] addSum;

  assign cntInc = cnt_q + CNT_W'(1);
  assign rstN   = ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The first chunk is loaded straight into the accumulator; later chunks go through the adder.
  always_comb begin
    state_d  = state_q;
    accum_d  = accum_q;
    partOp_d = partOp_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    addEn_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num_chunks;
          cnt_d   = '0;
          accum_d = '0;
          state_d = (num_chunks == '0) ? DONE : WAIT_PART;
        end
      end
      WAIT_PART: begin
        if (part_vld) begin
          if (cnt_q == '0) begin
            accum_d = part_data;
            cnt_d   = cntInc;
            if (cntInc == num_q) begin
              state_d = DONE;
            end
          end else begin
            partOp_d = part_data;
            addEn_d  = 1'b1;
            state_d  = ADD;
          end
        end
      end
      ADD: begin
        if (addVld) begin
          accum_d = addSum;
          cnt_d   = cntInc;
          state_d = (cntInc == num_q) ? DONE : WAIT_PART;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    result_d = (state_d == DONE) ? accum_d : result_q;
    // A stray part_vld in IDLE wins over the clear from a simultaneous start.
    err_d = ((state_q == IDLE) && part_vld) ||
            (err_q && !((state_q == IDLE) && start));
  end

  always_comb begin
    part_rdy   = (state_q == WAIT_PART);
    result_vld = (state_q == DONE);
    busy       = (state_q != IDLE);
    result     = result_q;
    err        = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accum_q  <= '0;
      partOp_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      num_q    <= '0;
      addEn_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      accum_q  <= accum_d;
      partOp_q <= partOp_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      addEn_q  <= addEn_d;
      err_q    <= err_d;
    end
  end

  fp_arith u_adder (
    .clk          (clk),
    .rst_n        (rstN),
    .en           (addEn_q),
    .op_sel       (FP_OP_ADD),
    .data_1       (accum_q),
    .data_2       (partOp_q),
    .data_accum_o (addSum),
    .data_o_vld   (addVld)
  );

endmodule

// File: tb/tb_svm_chunk_accum.sv
// Directed self-checking bench for svm_chunk_accum with hand-computed expectations.
module tb_svm_chunk_accum;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_chunks;
  logic [DW-1:0] part_data;
  logic          part_vld;
  logic          part_rdy;
  logic [DW-1:0] result;
  logic          result_vld;
  logic          busy;
  logic          err;

  int vectors     = 0;
  int miscompares = 0;
  int enCount     = 0;
  int enBase      = 0;
  int vldSeen     = 0;

  svm_chunk_accum #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_chunks (num_chunks),
    .part_data  (part_data),
    .part_vld   (part_vld),
    .part_rdy   (part_rdy),
    .result     (result),
    .result_vld (result_vld),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Adder enable pulses are counted to confirm the first chunk bypasses the adder.
  always @(posedge clk) begin
    if (dut.addEn_q) enCount <= enCount + 1;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStart(input logic [CW-1:0] num);
    start      = 1'b1;
    num_chunks = num;
    step();
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] data);
    int guard = 0;
    part_vld  = 1'b1;
    part_data = data;
    while (part_rdy !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    checkOutput("part_rdy_wait", {31'b0, part_rdy}, 32'd1);
    step();
    part_vld = 1'b0;
  endtask

  task automatic waitResult(input string tag);
    int guard = 0;
    while (result_vld !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    checkOutput({tag, "_vld"}, {31'b0, result_vld}, 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    num_chunks = '0;
    part_data  = '0;
    part_vld   = 1'b0;
    step(2);
    checkOutput("rst_result", result, 32'h0);
    checkOutput("rst_result_vld", {31'b0, result_vld}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_part_rdy", {31'b0, part_rdy}, 32'd0);
    rst = 1'b0;
    step();

    // Single chunk: passes straight through with no adder activity.
    enBase = enCount;
    applyStart(8'd1);
    checkOutput("one_busy", {31'b0, busy}, 32'd1);
    applyStimulus(32'h3F800000);
    checkOutput("one_vld", {31'b0, result_vld}, 32'd1);
    checkOutput("one_result", result, 32'h3F800000);
    checkOutput("one_en_count", enCount - enBase, 32'd0);
    step();
    checkOutput("one_vld_drop", {31'b0, result_vld}, 32'd0);
    checkOutput("one_busy_drop", {31'b0, busy}, 32'd0);
    checkOutput("one_result_hold", result, 32'h3F800000);

    // Three chunks: 1.0 + 2.0 + 3.0 = 6.0 with two adds.
    enBase = enCount;
    applyStart(8'd3);
    applyStimulus(32'h3F800000);
    applyStimulus(32'h40000000);
    applyStimulus(32'h40400000);
    waitResult("three");
    checkOutput("three_result", result, 32'h40C00000);
    checkOutput("three_en_count", enCount - enBase, 32'd2);
    step();
    checkOutput("three_busy_drop", {31'b0, busy}, 32'd0);

    // Zero chunks: immediate zero result, never ready for data.
    applyStart(8'd0);
    checkOutput("zero_vld", {31'b0, result_vld}, 32'd1);
    checkOutput("zero_result", result, 32'h0);
    checkOutput("zero_part_rdy", {31'b0, part_rdy}, 32'd0);
    step();
    checkOutput("zero_part_rdy_after", {31'b0, part_rdy}, 32'd0);
    checkOutput("zero_busy_drop", {31'b0, busy}, 32'd0);

    // Two chunks with a gap and a stray start during ADD.
    applyStart(8'd2);
    applyStimulus(32'h3F800000);
    step(5);
    checkOutput("gap_part_rdy", {31'b0, part_rdy}, 32'd1);
    applyStimulus(32'h40000000);
    checkOutput("gap_in_add_rdy", {31'b0, part_rdy}, 32'd0);
    start      = 1'b1;
    num_chunks = 8'd7;
    step();
    start = 1'b0;
    waitResult("gap");
    checkOutput("gap_result", result, 32'h40400000);
    step();
    checkOutput("gap_busy_drop", {31'b0, busy}, 32'd0);
    step(3);
    checkOutput("gap_stray_start_ignored", {31'b0, busy}, 32'd0);

    // Stray part_vld in IDLE sets a sticky error.
    part_vld  = 1'b1;
    part_data = 32'h41000000;
    step();
    part_vld = 1'b0;
    checkOutput("err_set", {31'b0, err}, 32'd1);
    checkOutput("err_idle_rdy", {31'b0, part_rdy}, 32'd0);
    step(3);
    checkOutput("err_sticky", {31'b0, err}, 32'd1);

    // start together with part_vld: start taken, data not consumed, err set.
    start      = 1'b1;
    num_chunks = 8'd1;
    part_vld   = 1'b1;
    part_data  = 32'h41000000;
    step();
    start    = 1'b0;
    part_vld = 1'b0;
    checkOutput("err_with_start", {31'b0, err}, 32'd1);
    checkOutput("err_with_start_busy", {31'b0, busy}, 32'd1);
    applyStimulus(32'h40A00000);
    checkOutput("err_with_start_result", result, 32'h40A00000);
    step();

    applyStart(8'd1);
    checkOutput("err_cleared", {31'b0, err}, 32'd0);
    applyStimulus(32'h40000000);
    checkOutput("err_run_result", result, 32'h40000000);
    step();

    // Maximum chunk count: 255 x 1.0 = 255.0.
    applyStart(8'd255);
    for (int k = 0; k < 255; k++) begin
      applyStimulus(32'h3F800000);
    end
    waitResult("max");
    checkOutput("max_result", result, 32'h437F0000);
    step();

    // Reset in the middle of an ADD.
    applyStart(8'd3);
    applyStimulus(32'h3F800000);
    applyStimulus(32'h40000000);
    checkOutput("midrst_pre_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_result", result, 32'h0);
    checkOutput("midrst_result_vld", {31'b0, result_vld}, 32'd0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst_err", {31'b0, err}, 32'd0);
    checkOutput("midrst_part_rdy", {31'b0, part_rdy}, 32'd0);
    step(2);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (result_vld === 1'b1 || busy === 1'b1) vldSeen++;
    end
    checkOutput("midrst_quiet", vldSeen, 32'd0);

    applyStart(8'd1);
    applyStimulus(32'h40490FDB);
    checkOutput("postrst_vld", {31'b0, result_vld}, 32'd1);
    checkOutput("postrst_result", result, 32'h40490FDB);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
